fir_l3_feed_ctrl: RTL and testbench

FIR_L3_FEED_CTRL -- requirements
Module: fir_l3_feed_ctrl

---
 rtl/fir_l3_feed_ctrl.sv | 152 +++++++++++++++
 tb/tb_fir_l3_feed_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/fir_l3_feed_ctrl.sv
// Feed controller for an L=3 parallel FIR: walks a 3-port sample ROM block by block,
// registers the lanes into the FIR and tracks output validity. FEED_CTRL_LOOP_EN wraps addresses until stop.

module fir_l3_feed_lane #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         vld,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);
  logic [W-1:0] dout_d, dout_q;

  // Lanes are forced to zero on idle cycles so the FIR never sees stale samples.
  always_comb dout_d = vld ? din : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) dout_q <= '0;
    else          dout_q <= dout_d;
  end

  assign dout = dout_q;
endmodule

module fir_l3_feed_ctrl #(
  parameter int DATA_IN_WIDTH = 16,
  parameter int ADDR_WIDTH    = 9,
  parameter int PIPE_LATENCY  = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     stop,
  input  logic [ADDR_WIDTH-1:0]    frame_blocks,
  output logic [ADDR_WIDTH-1:0]    rom_addr,
  input  logic [DATA_IN_WIDTH-1:0] rom_data_1,
  input  logic [DATA_IN_WIDTH-1:0] rom_data_2,
  input  logic [DATA_IN_WIDTH-1:0] rom_data_3,
  output logic [DATA_IN_WIDTH-1:0] fir_data_1,
  output logic [DATA_IN_WIDTH-1:0] fir_data_2,
  output logic [DATA_IN_WIDTH-1:0] fir_data_3,
  output logic                     fir_in_valid,
  output logic                     fir_out_valid,
  output logic                     busy,
  output logic                     done
);
  localparam int NUM_LANES = 3;
  localparam logic [ADDR_WIDTH-1:0]   ONE       = ADDR_WIDTH'(1);
  localparam logic [PIPE_LATENCY-1:0] TAIL_MASK = {PIPE_LATENCY{1'b1}} >> 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e                  state_d, state_q;
  logic [ADDR_WIDTH-1:0]   rom_addr_d, rom_addr_q;
  logic [ADDR_WIDTH-1:0]   frame_blocks_d, frame_blocks_q;
  logic                    issue;
  logic                    last_addr;
  logic                    pending;
  logic                    rd_vld_q;
  logic                    fir_in_valid_q;
  logic [PIPE_LATENCY-1:0] vld_pipe_d, vld_pipe_q;

  logic [NUM_LANES-1:0][DATA_IN_WIDTH-1:0] rom_lanes, fir_lanes;

  assign last_addr = (rom_addr_q == frame_blocks_q - ONE);
  // Output stage is excluded: its valid completes in the same cycle DONE is entered.
  assign pending   = rd_vld_q | fir_in_valid_q | (|(vld_pipe_q & TAIL_MASK));

  always_comb begin
    state_d        = state_q;
    rom_addr_d     = rom_addr_q;
    frame_blocks_d = frame_blocks_q;
    issue          = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          if (frame_blocks == '0) begin
            state_d = DONE;
          end else begin
            state_d        = RUN;
            rom_addr_d     = '0;
            frame_blocks_d = frame_blocks;
          end
        end
      end
      RUN: begin
        issue = 1'b1;
        if (stop) begin
          state_d = DRAIN;
        end else if (last_addr) begin
`ifdef FEED_CTRL_LOOP_EN
          rom_addr_d = '0;
`else
          state_d = DRAIN;
`endif
        end else begin
          rom_addr_d = rom_addr_q + ONE;
        end
      end
      DRAIN: begin
        if (!pending) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    vld_pipe_d[0] = fir_in_valid_q;
    for (int i = 1; i < PIPE_LATENCY; i++) vld_pipe_d[i] = vld_pipe_q[i-1];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      rom_addr_q     <= '0;
      frame_blocks_q <= '0;
      rd_vld_q       <= 1'b0;
      fir_in_valid_q <= 1'b0;
      vld_pipe_q     <= '0;
    end else begin
      state_q        <= state_d;
      rom_addr_q     <= rom_addr_d;
      frame_blocks_q <= frame_blocks_d;
      rd_vld_q       <= issue;
      fir_in_valid_q <= rd_vld_q;
      vld_pipe_q     <= vld_pipe_d;
    end
  end

  assign rom_lanes = {rom_data_3, rom_data_2, rom_data_1};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    fir_l3_feed_lane #(.W(DATA_IN_WIDTH)) u_lane (
      .clk     (clk),
      .reset_n (reset_n),
      .vld     (rd_vld_q),
      .din     (rom_lanes[g]),
      .dout    (fir_lanes[g])
    );
  end

  assign rom_addr      = rom_addr_q;
  assign fir_data_1    = fir_lanes[0];
  assign fir_data_2    = fir_lanes[1];
  assign fir_data_3    = fir_lanes[2];
  assign fir_in_valid  = fir_in_valid_q;
  assign fir_out_valid = vld_pipe_q[PIPE_LATENCY-1];
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);
endmodule

// File: tb/tb_fir_l3_feed_ctrl.sv
// Directed and randomized frames for fir_l3_feed_ctrl, checked against a cycle-index model
// of the expected address, lane, valid, busy and done timeline.
module tb_fir_l3_feed_ctrl;
  localparam int DW = 16;
  localparam int AW = 9;
  localparam int P  = 4;
  localparam int ROM_N = 3 * (1 << AW);
`ifdef FEED_CTRL_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [AW-1:0] frame_blocks = '0;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data_1 = '0, rom_data_2 = '0, rom_data_3 = '0;
  logic [DW-1:0] fir_data_1, fir_data_2, fir_data_3;
  logic          fir_in_valid, fir_out_valid, busy, done;

  logic [DW-1:0] rom_mem [0:ROM_N-1];
  int n_checks = 0;
  int n_err = 0;

  fir_l3_feed_ctrl #(.DATA_IN_WIDTH(DW), .ADDR_WIDTH(AW), .PIPE_LATENCY(P)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
    .frame_blocks(frame_blocks), .rom_addr(rom_addr),
    .rom_data_1(rom_data_1), .rom_data_2(rom_data_2), .rom_data_3(rom_data_3),
    .fir_data_1(fir_data_1), .fir_data_2(fir_data_2), .fir_data_3(fir_data_3),
    .fir_in_valid(fir_in_valid), .fir_out_valid(fir_out_valid),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Synchronous 3-port ROM, one cycle read latency.
  always @(posedge clk) begin
    rom_data_1 <= rom_mem[3 * int'(rom_addr)];
    rom_data_2 <= rom_mem[3 * int'(rom_addr) + 1];
    rom_data_3 <= rom_mem[3 * int'(rom_addr) + 2];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int addr_of(input int j, input int fb, input bit lp);
    return lp ? (j % fb) : j;
  endfunction

  task automatic fill_random();
    for (int i = 0; i < ROM_N; i++) rom_mem[i] = DW'($urandom);
  endtask

  // Start a frame and check every cycle up to 3 past done.
  // Cycle 0 is the cycle in which start is sampled; stop_c/xstart_c pulse stop/start in that cycle.
  task automatic run_frame(input int fb, input int stop_c, input int xstart_c, input bit lp);
    int n, done_c, a, n_fiv, n_fov;
    logic [3*DW-1:0] exp_lanes;
    bit efiv, efov;
    n_fiv = 0;
    n_fov = 0;
    if (lp) n = (fb == 0) ? 0 : stop_c;
    else    n = (stop_c >= 1 && stop_c <= fb) ? stop_c : fb;
    done_c = (n == 0) ? 1 : n + 3 + P;
    @(negedge clk);
    start = 1'b1;
    frame_blocks = AW'(fb);
    for (int c = 1; c <= done_c + 3; c++) begin
      @(negedge clk);
      start = (c == xstart_c);
      frame_blocks = AW'($urandom);
      efiv = (n > 0) && (c >= 3) && (c <= n + 2);
      efov = (n > 0) && (c >= 3 + P) && (c <= n + 2 + P);
      exp_lanes = '0;
      if (efiv) begin
        a = addr_of(c - 3, fb, lp);
        exp_lanes = {rom_mem[3*a], rom_mem[3*a+1], rom_mem[3*a+2]};
      end
      if (fir_in_valid)  n_fiv++;
      if (fir_out_valid) n_fov++;
      check("fir_in_valid",  64'(fir_in_valid), 64'(efiv));
      check("fir_data",      64'({fir_data_1, fir_data_2, fir_data_3}), 64'(exp_lanes));
      check("fir_out_valid", 64'(fir_out_valid), 64'(efov));
      check("done",          64'(done), 64'(c == done_c));
      check("busy",          64'(busy), 64'(c <= done_c));
      if (n > 0 && c <= n)  check("rom_addr",      64'(rom_addr), 64'(addr_of(c - 1, fb, lp)));
      if (n > 0 && c > n)   check("rom_addr_hold", 64'(rom_addr), 64'(addr_of(n - 1, fb, lp)));
      stop = (c == stop_c);
    end
    stop = 1'b0;
    start = 1'b0;
    check("fiv_count", 64'(n_fiv), 64'(n));
    check("fov_count", 64'(n_fov), 64'(n));
  endtask

  initial begin
    int fb, sc;
    fill_random();
    #3;
    check("rst_outputs", 64'({rom_addr, fir_data_1, fir_data_2, fir_data_3, fir_in_valid, fir_out_valid, busy, done}), 64'(0));
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("idle_after_rst", 64'({busy, done, fir_in_valid, fir_out_valid}), 64'(0));

    // start and stop together: stop wins, no frame begins
    start = 1'b1;
    stop = 1'b1;
    frame_blocks = AW'(5);
    @(negedge clk);
    start = 1'b0;
    stop = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("startstop_idle", 64'({busy, done, fir_in_valid}), 64'(0));
      @(negedge clk);
    end

    // empty frame: done next cycle, nothing valid
    run_frame(0, 0, 0, LOOP);

`ifdef FEED_CTRL_LOOP_EN
    run_frame(3, 8, 0, 1'b1);
    run_frame(1, 5, 4, 1'b1);
    for (int t = 0; t < 4; t++) begin
      fb = $urandom_range(1, 7);
      sc = $urandom_range(1, 20);
      run_frame(fb, sc, 0, 1'b1);
    end
`else
    run_frame(4, 0, 0, 1'b0);
    for (int i = 0; i < 510; i++)
      rom_mem[i] = DW'($rtoi(20000.0 * $sin(6.283185307 * real'(i) / 510.0)));
    run_frame(170, 0, 0, 1'b0);
    fill_random();
    run_frame(10, 3, 0, 1'b0);
    run_frame(1, 0, 0, 1'b0);
    run_frame(5, 1, 0, 1'b0);
    run_frame(3, 6, 2, 1'b0);
    run_frame(6, 0, 5, 1'b0);
    for (int t = 0; t < 5; t++) begin
      fb = $urandom_range(1, 12);
      sc = $urandom_range(0, 16);
      run_frame(fb, sc, 0, 1'b0);
    end
`endif

    // reset mid-frame: everything clears at once, nothing reappears until a new start
    @(negedge clk);
    start = 1'b1;
    frame_blocks = AW'(20);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_outputs", 64'({rom_addr, fir_data_1, fir_data_2, fir_data_3, fir_in_valid, fir_out_valid, busy, done}), 64'(0));
    #100;
    check("rst_held_outputs", 64'({rom_addr, fir_in_valid, fir_out_valid, busy, done}), 64'(0));
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      check("post_rst_quiet", 64'({fir_in_valid, fir_out_valid, busy, done}), 64'(0));
    end
    run_frame(2, LOOP ? 4 : 0, 0, LOOP);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
